// File: rtl/alu_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_input_ctrl
// Brief    : Debounced "execute" button front end that latches switch operands
//            and opcode, pulses start to the ALU and counts completed ops.
//            Define ALU_IN_SYNC_EN to put a two-flop synchronizer on btn_go.
// Revision : 1.0 - initial release
// ============================================================================
module alu_input_ctrl #(
    parameter int DB_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] sw_a,
    input  logic [2:0] sw_b,
    input  logic [1:0] sw_op,
    input  logic       btn_go,
    input  logic       alu_done,
    output logic [2:0] portA,
    output logic [2:0] portB,
    output logic [1:0] opcode,
    output logic       start,
    output logic       busy,
    output logic [7:0] op_count
);

    localparam int          c_CNT_W    = 16;
    localparam logic [15:0] c_CNT_LAST = c_CNT_W'(DB_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DEBOUNCE = 3'd1,
        S_START    = 3'd2,
        S_WAIT     = 3'd3,
        S_RELEASE  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_next;
    logic                w_load;
    logic                w_done;
    logic                w_btn_s;
    logic [2:0]          r_port_a;
    logic [2:0]          r_port_b;
    logic [1:0]          r_opcode;
    logic                r_start;
    logic                r_busy;
    logic [7:0]          r_op_count;

`ifdef ALU_IN_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], btn_go};
        end
    end

    assign w_btn_s = r_sync[1];
`else
    assign w_btn_s = btn_go;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_port_a   <= 3'd0;
            r_port_b   <= 3'd0;
            r_opcode   <= 2'd0;
            r_start    <= 1'b0;
            r_busy     <= 1'b0;
            r_op_count <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_load) begin
                r_port_a <= sw_a;
                r_port_b <= sw_b;
                r_opcode <= sw_op;
            end
            // Flags are derived from the next state so they are registered yet
            // line up exactly with the state they describe.
            r_start    <= (w_state_next == S_START);
            r_busy     <= (w_state_next == S_START) || (w_state_next == S_WAIT);
            r_op_count <= r_op_count + {7'd0, w_done};
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_load       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_btn_s) begin
                    w_state_next = S_DEBOUNCE;
                    w_cnt_next   = '0;
                end
            end
            S_DEBOUNCE: begin
                if (!w_btn_s) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_next = S_START;
                    w_cnt_next   = '0;
                    w_load       = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            S_START: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (alu_done) begin
                    w_state_next = S_RELEASE;
                    w_cnt_next   = '0;
                    w_done       = 1'b1;
                end
            end
            S_RELEASE: begin
                // Any bounce back high restarts the release qualification.
                if (w_btn_s) begin
                    w_cnt_next = '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign portA    = r_port_a;
    assign portB    = r_port_b;
    assign opcode   = r_opcode;
    assign start    = r_start;
    assign busy     = r_busy;
    assign op_count = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_input_ctrl
// Brief    : Directed self-checking bench for alu_input_ctrl with DB_CYCLES = 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_input_ctrl;

    localparam int c_DB = 4;
`ifdef ALU_IN_SYNC_EN
    localparam int c_LAT = c_DB + 1 + 2;
`else
    localparam int c_LAT = c_DB + 1;
`endif

    logic       clk;
    logic       rst;
    logic [2:0] sw_a;
    logic [2:0] sw_b;
    logic [1:0] sw_op;
    logic       btn_go;
    logic       alu_done;
    logic [2:0] portA;
    logic [2:0] portB;
    logic [1:0] opcode;
    logic       start;
    logic       busy;
    logic [7:0] op_count;

    int n_pass  = 0;
    int n_total = 0;
    int glitch;

    alu_input_ctrl #(.DB_CYCLES(c_DB)) dut (
        .clk      (clk),
        .rst      (rst),
        .sw_a     (sw_a),
        .sw_b     (sw_b),
        .sw_op    (sw_op),
        .btn_go   (btn_go),
        .alu_done (alu_done),
        .portA    (portA),
        .portB    (portB),
        .opcode   (opcode),
        .start    (start),
        .busy     (busy),
        .op_count (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation did not complete");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op();
        int found;
        found  = 0;
        btn_go = 1'b1;
        for (int k = 0; k < 30 && found == 0; k++) begin
            step();
            if (start === 1'b1) found = 1;
        end
        n_total++;
        if (found === 1) n_pass++;
        else $error("FAIL op_start_seen: observed %0d expected 1", found);
        step();
        alu_done = 1'b1;
        step();
        alu_done = 1'b0;
        btn_go   = 1'b0;
        repeat (12) step();
    endtask

    initial begin
        rst = 1'b1; sw_a = 3'd0; sw_b = 3'd0; sw_op = 2'd0;
        btn_go = 1'b0; alu_done = 1'b0;
        step();
        n_total++; if (portA === 3'd0) n_pass++; else $error("FAIL rst_portA: observed %0d expected 0", portA);
        n_total++; if (portB === 3'd0) n_pass++; else $error("FAIL rst_portB: observed %0d expected 0", portB);
        n_total++; if (opcode === 2'd0) n_pass++; else $error("FAIL rst_opcode: observed %0d expected 0", opcode);
        n_total++; if (start === 1'b0) n_pass++; else $error("FAIL rst_start: observed %0d expected 0", start);
        n_total++; if (busy === 1'b0) n_pass++; else $error("FAIL rst_busy: observed %0d expected 0", busy);
        n_total++; if (op_count === 8'd0) n_pass++; else $error("FAIL rst_op_count: observed %0d expected 0", op_count);
        step();
        rst = 1'b0;
        repeat (3) step();

        sw_a = 3'd5; sw_b = 3'd3; sw_op = 2'b10; btn_go = 1'b1;
        glitch = 0;
        for (int k = 1; k < c_LAT; k++) begin
            step();
            if (start === 1'b1) glitch++;
        end
        n_total++; if (glitch === 0) n_pass++; else $error("FAIL no_early_start: observed %0d expected 0", glitch);
        n_total++; if (portA === 3'd0) n_pass++; else $error("FAIL portA_before_load: observed %0d expected 0", portA);
        step();
        n_total++; if (start === 1'b1) n_pass++; else $error("FAIL start_at_latency: observed %0d expected 1", start);
        n_total++; if (portA === 3'd5) n_pass++; else $error("FAIL portA_at_start: observed %0d expected 5", portA);
        n_total++; if (portB === 3'd3) n_pass++; else $error("FAIL portB_at_start: observed %0d expected 3", portB);
        n_total++; if (opcode === 2'b10) n_pass++; else $error("FAIL opcode_at_start: observed %0d expected 2", opcode);
        n_total++; if (busy === 1'b1) n_pass++; else $error("FAIL busy_at_start: observed %0d expected 1", busy);
        step();
        n_total++; if (start === 1'b0) n_pass++; else $error("FAIL start_one_cycle: observed %0d expected 0", start);
        n_total++; if (busy === 1'b1) n_pass++; else $error("FAIL busy_in_wait: observed %0d expected 1", busy);
        sw_a = 3'd7; sw_b = 3'd7; sw_op = 2'b11;
        repeat (3) step();
        alu_done = 1'b1;
        n_total++; if (op_count === 8'd0) n_pass++; else $error("FAIL op_count_before_done: observed %0d expected 0", op_count);
        step();
        alu_done = 1'b0;
        n_total++; if (op_count === 8'd1) n_pass++; else $error("FAIL op_count_after_done: observed %0d expected 1", op_count);
        n_total++; if (busy === 1'b0) n_pass++; else $error("FAIL busy_after_done: observed %0d expected 0", busy);
        n_total++; if (portA === 3'd5) n_pass++; else $error("FAIL portA_held: observed %0d expected 5", portA);
        n_total++; if (portB === 3'd3) n_pass++; else $error("FAIL portB_held: observed %0d expected 3", portB);
        n_total++; if (opcode === 2'b10) n_pass++; else $error("FAIL opcode_held: observed %0d expected 2", opcode);
        glitch = 0;
        repeat (20) begin
            step();
            if (start === 1'b1) glitch++;
        end
        n_total++; if (glitch === 0) n_pass++; else $error("FAIL held_no_retrigger: observed %0d expected 0", glitch);
        btn_go = 1'b0;
        repeat (12) step();

        btn_go = 1'b1;
        repeat (3) step();
        btn_go = 1'b0;
        glitch = 0;
        repeat (15) begin
            step();
            if (start === 1'b1) glitch++;
        end
        n_total++; if (glitch === 0) n_pass++; else $error("FAIL bounce3_no_start: observed %0d expected 0", glitch);
        n_total++; if (portA === 3'd5) n_pass++; else $error("FAIL bounce_portA: observed %0d expected 5", portA);
        n_total++; if (opcode === 2'b10) n_pass++; else $error("FAIL bounce_opcode: observed %0d expected 2", opcode);
        n_total++; if (busy === 1'b0) n_pass++; else $error("FAIL bounce_busy: observed %0d expected 0", busy);

        btn_go = 1'b1;
        repeat (c_DB) step();
        btn_go = 1'b0;
        glitch = 0;
        repeat (15) begin
            step();
            if (start === 1'b1) glitch++;
        end
        n_total++; if (glitch === 0) n_pass++; else $error("FAIL bounce4_no_start: observed %0d expected 0", glitch);

        btn_go = 1'b1;
        glitch = 0;
        repeat (c_DB + 1) begin
            step();
            if (start === 1'b1) glitch++;
        end
        btn_go = 1'b0;
        repeat (4) begin
            step();
            if (start === 1'b1) glitch++;
        end
        n_total++; if (glitch === 1) n_pass++; else $error("FAIL bounce5_one_start: observed %0d expected 1", glitch);
        n_total++; if (portA === 3'd7) n_pass++; else $error("FAIL bounce5_portA: observed %0d expected 7", portA);
        n_total++; if (opcode === 2'b11) n_pass++; else $error("FAIL bounce5_opcode: observed %0d expected 3", opcode);
        alu_done = 1'b1;
        step();
        alu_done = 1'b0;
        n_total++; if (op_count === 8'd2) n_pass++; else $error("FAIL bounce5_op_count: observed %0d expected 2", op_count);
        repeat (12) step();

        sw_a = 3'd1; sw_b = 3'd2; sw_op = 2'b01; btn_go = 1'b1;
        repeat (c_LAT) step();
        n_total++; if (start === 1'b1) n_pass++; else $error("FAIL op3_start: observed %0d expected 1", start);
        n_total++; if (portB === 3'd2) n_pass++; else $error("FAIL op3_portB: observed %0d expected 2", portB);
        alu_done = 1'b1;
        step();
        alu_done = 1'b0;
        n_total++; if (op_count === 8'd2) n_pass++; else $error("FAIL done_in_start_ignored: observed %0d expected 2", op_count);
        n_total++; if (busy === 1'b1) n_pass++; else $error("FAIL busy_after_start_done: observed %0d expected 1", busy);
        step();
        #3 rst = 1'b1;
        #1;
        n_total++; if (portA === 3'd0) n_pass++; else $error("FAIL async_rst_portA: observed %0d expected 0", portA);
        n_total++; if (portB === 3'd0) n_pass++; else $error("FAIL async_rst_portB: observed %0d expected 0", portB);
        n_total++; if (opcode === 2'd0) n_pass++; else $error("FAIL async_rst_opcode: observed %0d expected 0", opcode);
        n_total++; if (busy === 1'b0) n_pass++; else $error("FAIL async_rst_busy: observed %0d expected 0", busy);
        n_total++; if (op_count === 8'd0) n_pass++; else $error("FAIL async_rst_op_count: observed %0d expected 0", op_count);
        step();
        rst = 1'b0;
        glitch = 0;
        for (int k = 1; k < c_LAT; k++) begin
            step();
            if (start === 1'b1) glitch++;
        end
        n_total++; if (glitch === 0) n_pass++; else $error("FAIL post_rst_full_debounce: observed %0d expected 0", glitch);
        step();
        n_total++; if (start === 1'b1) n_pass++; else $error("FAIL post_rst_start: observed %0d expected 1", start);
        step();
        alu_done = 1'b1;
        step();
        alu_done = 1'b0;
        btn_go   = 1'b0;
        n_total++; if (op_count === 8'd1) n_pass++; else $error("FAIL post_rst_op_count: observed %0d expected 1", op_count);
        repeat (12) step();

        for (int i = 0; i < 254; i++) do_op();
        n_total++; if (op_count === 8'd255) n_pass++; else $error("FAIL op_count_255: observed %0d expected 255", op_count);
        do_op();
        n_total++; if (op_count === 8'd0) n_pass++; else $error("FAIL op_count_wrap: observed %0d expected 0", op_count);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_input_ctrl.md
ALU_INPUT_CTRL -- requirements
Module: alu_input_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 50000, consecutive stable cycles required to accept a button level (legal range 2..65535).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 sw_a  input  3  operand A switches.
REQ-005 sw_b  input  3  operand B switches.
REQ-006 sw_op  input  2  opcode switches (00 add, 01 sub, 10 mul, 11 div).
REQ-007 btn_go  input  1  raw "execute" push button, active-high, asynchronous to clk.
REQ-008 alu_done  input  1  ALU result-ready strobe, sampled only in WAIT.
REQ-009 portA  output  3  registered operand A to ALU.
REQ-010 portB  output  3  registered operand B to ALU.
REQ-011 opcode  output  2  registered opcode to ALU.
REQ-012 start  output  1  one-cycle ALU init pulse.
REQ-013 busy  output  1  high from START through WAIT inclusive.
REQ-014 op_count  output  8  number of completed operations.

Function
REQ-015 FSM states: IDLE, DEBOUNCE, START, WAIT, RELEASE; all outputs registered.
REQ-016 IDLE: btn_s (button after optional sync, REQ-030) high -> DEBOUNCE with debounce counter cleared to 0; else stay.
REQ-017 DEBOUNCE: counter increments each cycle btn_s high; btn_s low -> IDLE, counter cleared.
REQ-018 DEBOUNCE with counter == DB_CYCLES-1 and btn_s high -> START; portA/portB/opcode load sw_a/sw_b/sw_op on that same edge.
REQ-019 START lasts exactly one cycle; start = 1 only in START; portA/portB/opcode already valid that cycle; unconditional -> WAIT.
REQ-020 alu_done during START ignored.
REQ-021 WAIT: hold outputs; alu_done high -> RELEASE and op_count increments by 1 on that edge.
REQ-022 op_count wraps 255 -> 0 without flag.
REQ-023 RELEASE: counter counts consecutive btn_s-low cycles, cleared on any btn_s high; counter == DB_CYCLES-1 with btn_s low -> IDLE.
REQ-024 A held button never retriggers; a new operation requires a debounced release then a debounced press.
REQ-025 Switch changes outside the REQ-018 load edge never alter portA/portB/opcode.
REQ-026 Latency: first btn_s-high cycle in IDLE = cycle 0; start high in cycle DB_CYCLES+1 (no glitches in between).
REQ-027 busy = 1 in START and WAIT, 0 elsewhere.

Reset
REQ-028 rst high asynchronously forces IDLE, counter 0, portA 0, portB 0, opcode 00, start 0, busy 0, op_count 0, synchronizer flops 0.
REQ-029 Reset mid-operation (any state) aborts without a completion count; after rst deasserts, a fresh debounced press is required.

Configuration
REQ-030 Macro ALU_IN_SYNC_EN defined: btn_go passes a two-flop synchronizer before btn_s, adding exactly 2 cycles to all button-related latencies; undefined: btn_s = btn_go directly, no added latency.

Verification (DB_CYCLES = 4, ALU_IN_SYNC_EN undefined unless stated)
REQ-031 sw_a=5, sw_b=3, sw_op=10, btn_go high from cycle 0 -> start pulse exactly at cycle 5, portA=5, portB=3, opcode=10, busy=1.
REQ-032 btn_go high 3 cycles then low (bounce) -> no start, state returns to IDLE, outputs unchanged.
REQ-033 In WAIT change switches to 7/7/11, alu_done at cycle 9 -> outputs keep 5/3/10, op_count 0->1, busy drops next cycle; button held further -> no second start.
REQ-034 Assert rst during WAIT -> all outputs zero immediately (asynchronously), op_count 0; subsequent press restarts full debounce.
REQ-035 Run 256 complete operations -> op_count returns to 0.
REQ-036 ALU_IN_SYNC_EN defined, repeat REQ-031 -> start at cycle 7.
